// File: rtl/vend_credit_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : vend_credit_ctrl
// Brief   : Escrow credit sequencer that issues a vend strobe and returns change
//           one coin at a time over a req/ack hopper handshake.
//           Build option VEND_AUTO_VEND_EN: vend as soon as credit covers PRICE.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module vend_credit_ctrl #(
  parameter int unsigned PRICE      = 65,
  parameter int unsigned MAX_CREDIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_n,
  input  logic       coin_d,
  input  logic       coin_q,
  input  logic       buy,
  input  logic       cancel,
  input  logic       chg_ack,
  output logic [7:0] credit,
  output logic       dispense,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       chg_req,
  output logic [1:0] chg_coin,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;

  localparam logic [7:0] PRICE_C = 8'(PRICE);
  localparam logic [8:0] MAX_C   = 9'(MAX_CREDIT);

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_N    = 2'b01;
  localparam logic [1:0] COIN_D    = 2'b10;
  localparam logic [1:0] COIN_Q    = 2'b11;

  logic [1:0] state;
  logic       coin_any;
  logic       coin_one;
  logic       coin_room;
  logic       coin_ok;
  logic       coin_block;
  logic       can_vend;
  logic       vend_go;
  logic       refuse;
  logic [7:0] coin_val;
  logic [7:0] chg_val;
  logic [7:0] credit_after;

  // Greedy change selection: largest coin not exceeding the remaining credit.
  function automatic logic [1:0] pick_coin(input logic [7:0] c);
    if (c >= 8'd25)
      return COIN_Q;
    else if (c >= 8'd10)
      return COIN_D;
    else
      return COIN_N;
  endfunction

  always_comb begin
    coin_any  = coin_n | coin_d | coin_q;
    coin_one  = $onehot({coin_n, coin_d, coin_q});
    coin_val  = coin_q ? 8'd25 : (coin_d ? 8'd10 : 8'd5);
    coin_room = ({1'b0, credit} + {1'b0, coin_val}) <= MAX_C;
    can_vend  = (state == S_CREDIT) && (credit >= PRICE_C);
`ifdef VEND_AUTO_VEND_EN
    vend_go    = can_vend && !cancel;
    refuse     = 1'b0;
    coin_block = can_vend;
`else
    vend_go    = can_vend && buy && !cancel;
    refuse     = (state == S_CREDIT) && buy && !cancel && (credit < PRICE_C);
    coin_block = 1'b0;
`endif
    coin_ok = coin_one && coin_room && !buy && !cancel && !coin_block &&
              ((state == S_IDLE) || (state == S_CREDIT));
    chg_val = (chg_coin == COIN_Q) ? 8'd25 : ((chg_coin == COIN_D) ? 8'd10 : 8'd5);
    credit_after = credit - chg_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      credit       <= 8'd0;
      dispense     <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      chg_req      <= 1'b0;
      chg_coin     <= COIN_NONE;
      busy         <= 1'b0;
    end else begin
      dispense     <= 1'b0;
      coin_reject  <= coin_any && !coin_ok;
      insufficient <= refuse;
      case (state)
        S_IDLE: begin
          if (coin_ok) begin
            credit <= credit + coin_val;
            state  <= S_CREDIT;
          end
        end
        S_CREDIT: begin
          if (cancel) begin
            state    <= S_CHANGE;
            busy     <= 1'b1;
            chg_req  <= 1'b1;
            chg_coin <= pick_coin(credit);
          end else if (vend_go) begin
            state    <= S_VEND;
            busy     <= 1'b1;
            dispense <= 1'b1;
            credit   <= credit - PRICE_C;
          end else if (coin_ok) begin
            credit <= credit + coin_val;
          end
        end
        S_VEND: begin
          if (credit == 8'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= S_CHANGE;
            chg_req  <= 1'b1;
            chg_coin <= pick_coin(credit);
          end
        end
        default: begin
          // The coin for the next request is staged during the mandatory low cycle.
          if (chg_req && chg_ack) begin
            credit  <= credit_after;
            chg_req <= 1'b0;
            if (credit_after == 8'd0) begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              chg_coin <= COIN_NONE;
            end else begin
              chg_coin <= pick_coin(credit_after);
            end
          end else if (!chg_req) begin
            chg_req <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_credit_ctrl.sv
`default_nettype none
// Scoreboard bench: a transaction-level escrow model predicts pulses and change
// coins; a monitor pops expectations whenever the controller emits an event.
module tb_vend_credit_ctrl;

  localparam int PRICE = 65;
  localparam int MAXC  = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_n, coin_d, coin_q, buy, cancel, chg_ack;
  logic [7:0] credit;
  logic       dispense, coin_reject, insufficient, chg_req, busy;
  logic [1:0] chg_coin;

  vend_credit_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAXC)) dut (
    .clk(clk), .rst(rst), .coin_n(coin_n), .coin_d(coin_d), .coin_q(coin_q),
    .buy(buy), .cancel(cancel), .chg_ack(chg_ack), .credit(credit),
    .dispense(dispense), .coin_reject(coin_reject), .insufficient(insufficient),
    .chg_req(chg_req), .chg_coin(chg_coin), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int cred; } pulse_t;  // kind: 1 reject, 2 insufficient, 3 dispense
  typedef struct { int code; int cred; } chg_t;

  pulse_t q_pulse[$];
  chg_t   q_chg[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     m_credit = 0;
  bit     ack_en   = 1'b1;
  int     ack_dly  = -1;
  bit     prev_req = 1'b0;
  int     held     = 0;
  chg_t   mon_e;
  pulse_t mon_p;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_pulse(input int k, input int c);
    pulse_t p;
    p.kind = k;
    p.cred = c;
    q_pulse.push_back(p);
  endfunction

  // Greedy change list for an amount, each entry with the credit shown during its request.
  function automatic void push_change(input int amount);
    int c = amount;
    while (c > 0) begin
      chg_t e;
      e.cred = c;
      if (c >= 25) begin e.code = 3; c -= 25; end
      else if (c >= 10) begin e.code = 2; c -= 10; end
      else begin e.code = 1; c -= 5; end
      q_chg.push_back(e);
    end
  endfunction

  // Escrow rules applied to one input cycle issued while the controller is idle/credit.
  function automatic void model_apply(input bit n, input bit d, input bit q,
                                      input bit b, input bit c);
    int cnt = int'(n) + int'(d) + int'(q);
    int val = q ? 25 : (d ? 10 : 5);
    bit rej = (cnt > 0) && !(cnt == 1 && !b && !c && (m_credit + val <= MAXC));
    if (cnt > 0 && !rej) begin
      m_credit += val;
    end else if (m_credit > 0 && c) begin
      if (rej) push_pulse(1, m_credit);
      push_change(m_credit);
      m_credit = 0;
    end else if (m_credit > 0 && b && m_credit >= PRICE) begin
      m_credit -= PRICE;
      if (rej) push_pulse(1, m_credit);
      push_pulse(3, m_credit);
      push_change(m_credit);
      m_credit = 0;
    end else if (m_credit > 0 && b) begin
      if (rej) push_pulse(1, m_credit);
      push_pulse(2, m_credit);
    end else if (rej) begin
      push_pulse(1, m_credit);
    end
  endfunction

  task automatic pop_pulse(input int k, input string name);
    if (q_pulse.size() == 0) begin
      chk({"unexpected_", name}, 1, 0);
    end else begin
      mon_p = q_pulse.pop_front();
      chk({name, "_order"}, k, mon_p.kind);
      if (mon_p.cred >= 0) chk({name, "_credit"}, int'(credit), mon_p.cred);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (coin_reject)  pop_pulse(1, "coin_reject");
      if (insufficient) pop_pulse(2, "insufficient");
      if (dispense)     pop_pulse(3, "dispense");
      if (chg_req && !prev_req) begin
        if (q_chg.size() == 0) begin
          chk("unexpected_chg_req", 1, 0);
        end else begin
          mon_e = q_chg.pop_front();
          chk("chg_coin", int'(chg_coin), mon_e.code);
          chk("chg_credit", int'(credit), mon_e.cred);
        end
        held = int'(chg_coin);
      end else if (chg_req) begin
        chk("chg_coin_hold", int'(chg_coin), held);
      end
      prev_req = chg_req;
    end
  end

  // Hopper model
  initial begin
    chg_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && chg_req) begin
        int d;
        d = (ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 3));
        repeat (d) @(negedge clk);
        if (ack_en && chg_req) begin
          chg_ack = 1'b1;
          @(negedge clk);
          chg_ack = 1'b0;
        end
      end
    end
  end

  task automatic wait_quiet();
    int k = 0;
    #1;
    while (!(busy == 1'b0 && q_chg.size() == 0 && q_pulse.size() == 0) && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("settle_within_budget", int'(k < 300), 1);
    chk("credit", int'(credit), m_credit);
  endtask

  task automatic drive(input bit n, input bit d, input bit q, input bit b, input bit c);
    coin_n = n; coin_d = d; coin_q = q; buy = b; cancel = c;
  endtask

  task automatic txn(input bit n, input bit d, input bit q, input bit b, input bit c);
    @(negedge clk);
    drive(n, d, q, b, c);
    model_apply(n, d, q, b, c);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    wait_quiet();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_credit"},   int'(credit), 0);
    chk({tag, "_chg_req"},  int'(chg_req), 0);
    chk({tag, "_chg_coin"}, int'(chg_coin), 0);
    chk({tag, "_busy"},     int'(busy), 0);
    chk({tag, "_dispense"}, int'(dispense), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_coin_reject",  int'(coin_reject), 0);
    chk("reset_insufficient", int'(insufficient), 0);
    rst = 1'b0;

    // Exact price
    txn(0, 0, 1, 0, 0); txn(0, 0, 1, 0, 0); txn(0, 1, 0, 0, 0); txn(1, 0, 0, 0, 0);
    txn(0, 0, 0, 1, 0);
    // Overpay by a dime
    txn(0, 0, 1, 0, 0); txn(0, 0, 1, 0, 0); txn(0, 0, 1, 0, 0);
    txn(0, 0, 0, 1, 0);

    // Cancel at 40 with slow hopper and a coin arriving mid-change
    ack_dly = 3;
    txn(0, 0, 1, 0, 0); txn(0, 1, 0, 0, 0); txn(1, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    model_apply(0, 0, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 1, 0, 0);
    push_pulse(1, -1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    wait_quiet();
    ack_dly = -1;

    // Ceiling, then multi-coin from empty
    repeat (4) txn(0, 0, 1, 0, 0);
    txn(1, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 1);
    txn(1, 1, 0, 0, 0);

    // Insufficient, then buy+cancel
    txn(0, 0, 1, 0, 0); txn(0, 0, 1, 0, 0);
    txn(0, 0, 0, 1, 0);
    txn(0, 0, 0, 1, 1);

    // Reset while a change request awaits ack
    ack_en = 1'b0;
    txn(0, 0, 1, 0, 0); txn(0, 0, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    model_apply(0, 0, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("req_before_rst", int'(chg_req), 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    q_chg.delete();
    m_credit = 0;
    check_idle_outputs("mid_change_rst");
    chg_ack = 1'b1;
    @(negedge clk);
    #1;
    chg_ack = 1'b0;
    check_idle_outputs("stale_ack");
    ack_en = 1'b1;
    txn(0, 1, 0, 0, 0);
    txn(0, 0, 0, 0, 1);

    // Randomized transactions
    for (int i = 0; i < 250; i++) begin
      int r = int'($urandom_range(0, 9));
      bit n = 0, d = 0, q = 0, b = 0, c = 0;
      if (r <= 5) begin
        int w = int'($urandom_range(0, 2));
        n = (w == 0); d = (w == 1); q = (w == 2);
      end else if (r == 6) begin
        n = 1'($urandom); d = 1'($urandom); q = 1'b1;
      end else if (r == 7) begin
        b = 1'b1;
        if ($urandom_range(0, 4) == 0) n = 1'b1;
      end else if (r == 8) begin
        c = 1'b1;
        if ($urandom_range(0, 4) == 0) d = 1'b1;
      end else begin
        b = 1'b1; c = 1'b1;
      end
      txn(n, d, q, b, c);
    end
    txn(0, 0, 0, 0, 1);

    chk("pulse_queue_drained", q_pulse.size(), 0);
    chk("change_queue_drained", q_chg.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
